// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and constants for the dma copy engine
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dma_state_e;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_HI   = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int BUSY_BIT = 15;

endpackage

// File: rtl/dma_copy_engine_if.sv
// rtl/dma_copy_engine_if.sv - access/ack word bus shared by responder and initiator ports
interface dma_copy_engine_if;
    logic        access;
    logic        ack;
    logic [19:1] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        wr_en;
    logic [1:0]  bytesel;

    modport master (output access, addr, wdata, wr_en, bytesel, input ack, rdata);
    modport slave  (input access, addr, wdata, wr_en, bytesel, output ack, rdata);
endinterface

// File: rtl/dma_regs.sv
// rtl/dma_regs.sv - responder register file (SRC/DST/HI/CTRL), fill bit under CONFIG_DMA_FILL_EN
module dma_regs
    import dma_pkg::*;
#(
    parameter int COUNT_WIDTH = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cs,
    dma_copy_engine_if.slave       bus,
    input  logic                   busy,
    input  logic [COUNT_WIDTH-1:0] remaining,
    output logic [15:0]            src,
    output logic [15:0]            dst,
    output logic [3:0]             src_hi,
    output logic [3:0]             dst_hi,
    output logic                   fill_en,
    output logic                   ctrl_wr,
    output logic [COUNT_WIDTH-1:0] ctrl_val
);

    logic        ack_q, ack_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] src_q, src_d, dst_q, dst_d;
    logic [3:0]  src_hi_q, src_hi_d, dst_hi_q, dst_hi_d;
    logic        fill_q, fill_d;
    logic        accept, wr_accept;
    logic [1:0]  idx;
    logic [15:0] rd_mux;
    logic        unused_addr;

    // The ack cycle still sees access high, so it must not start a second access.
    assign accept      = cs & bus.access & ~ack_q;
    assign wr_accept   = accept & bus.wr_en;
    assign idx         = bus.addr[2:1];
    assign unused_addr = ^bus.addr[19:3];

    assign ctrl_wr  = wr_accept && (idx == REG_CTRL) && (bus.bytesel == 2'b11);
    assign ctrl_val = bus.wdata[COUNT_WIDTH-1:0];

    // Register read mux; unused HI bits read as zero.
    always_comb begin
        rd_mux = '0;
        case (idx)
            REG_SRC: rd_mux = src_q;
            REG_DST: rd_mux = dst_q;
            REG_HI: begin
                rd_mux[3:0]  = src_hi_q;
                rd_mux[11:8] = dst_hi_q;
                rd_mux[15]   = fill_q;
            end
            default: begin
                rd_mux[COUNT_WIDTH-1:0] = remaining;
                rd_mux[BUSY_BIT]        = busy;
            end
        endcase
    end

    // Ack/read-data generation and byte-merged register writes.
    always_comb begin
        ack_d    = accept;
        rdata_d  = (accept && !bus.wr_en) ? rd_mux : '0;
        src_d    = src_q;
        dst_d    = dst_q;
        src_hi_d = src_hi_q;
        dst_hi_d = dst_hi_q;
        fill_d   = fill_q;
        if (wr_accept) begin
            case (idx)
                REG_SRC: begin
                    if (bus.bytesel[0]) src_d[7:0]  = bus.wdata[7:0];
                    if (bus.bytesel[1]) src_d[15:8] = bus.wdata[15:8];
                end
                REG_DST: begin
                    if (bus.bytesel[0]) dst_d[7:0]  = bus.wdata[7:0];
                    if (bus.bytesel[1]) dst_d[15:8] = bus.wdata[15:8];
                end
                REG_HI: begin
                    if (bus.bytesel[0]) src_hi_d = bus.wdata[3:0];
                    if (bus.bytesel[1]) begin
                        dst_hi_d = bus.wdata[11:8];
`ifdef CONFIG_DMA_FILL_EN
                        fill_d   = bus.wdata[15];
`else
                        fill_d   = 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Register state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            src_hi_q <= '0;
            dst_hi_q <= '0;
            fill_q   <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            src_hi_q <= src_hi_d;
            dst_hi_q <= dst_hi_d;
            fill_q   <= fill_d;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
    assign src       = src_q;
    assign dst       = dst_q;
    assign src_hi    = src_hi_q;
    assign dst_hi    = dst_hi_q;
    assign fill_en   = fill_q;

endmodule

// File: rtl/dma_copy_engine.sv
// rtl/dma_copy_engine.sv - memory-to-memory word copier, fill mode under CONFIG_DMA_FILL_EN
module dma_copy_engine
    import dma_pkg::*;
#(
    parameter int COUNT_WIDTH = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cs,
    dma_copy_engine_if.slave   data_m,
    dma_copy_engine_if.master  dma_m,
    output logic               intr
);

    dma_state_e             state_q, state_d;
    logic                   acc_q, acc_d;
    logic [18:0]            cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
    logic [COUNT_WIDTH-1:0] rem_q, rem_d;
    logic [15:0]            data_q, data_d;
    logic                   abort_q, abort_d, fill_q, fill_d, intr_q, intr_d;
    logic                   busy, abort_now;

    logic [15:0]            src_reg, dst_reg;
    logic [3:0]             src_hi, dst_hi;
    logic                   fill_en, ctrl_wr;
    logic [COUNT_WIDTH-1:0] ctrl_val;

    assign busy = (state_q != IDLE);

    dma_regs #(.COUNT_WIDTH(COUNT_WIDTH)) u_regs (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .bus       (data_m),
        .busy      (busy),
        .remaining (rem_q),
        .src       (src_reg),
        .dst       (dst_reg),
        .src_hi    (src_hi),
        .dst_hi    (dst_hi),
        .fill_en   (fill_en),
        .ctrl_wr   (ctrl_wr),
        .ctrl_val  (ctrl_val)
    );

    // Transfer FSM: each beat spends one cycle with access low, then holds access until ack.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cur_src_d = cur_src_q;
        cur_dst_d = cur_dst_q;
        rem_d     = rem_q;
        data_d    = data_q;
        fill_d    = fill_q;
        intr_d    = intr_q;
        abort_now = abort_q | (ctrl_wr && busy && (ctrl_val == '0));
        abort_d   = abort_now;
        if (ctrl_wr) intr_d = 1'b0;
        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (ctrl_wr) begin
                    if (ctrl_val == '0) begin
                        intr_d = 1'b1;
                    end else begin
                        cur_src_d = {src_hi, src_reg[15:1]};
                        cur_dst_d = {dst_hi, dst_reg[15:1]};
                        rem_d     = ctrl_val;
                        data_d    = src_reg;
                        fill_d    = fill_en;
                        state_d   = fill_en ? WRITE : READ;
                    end
                end
            end
            READ: begin
                if (!acc_q) begin
                    acc_d = 1'b1;
                end else if (dma_m.ack) begin
                    acc_d   = 1'b0;
                    data_d  = dma_m.rdata;
                    state_d = abort_now ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (!acc_q) begin
                    acc_d = 1'b1;
                end else if (dma_m.ack) begin
                    acc_d     = 1'b0;
                    cur_dst_d = cur_dst_q + 19'd1;
                    if (!fill_q) cur_src_d = cur_src_q + 19'd1;
                    rem_d = rem_q - COUNT_WIDTH'(1);
                    if (rem_q == COUNT_WIDTH'(1) || abort_now) state_d = DONE;
                    else if (fill_q)                            state_d = WRITE;
                    else                                        state_d = READ;
                end
            end
            default: begin
                intr_d  = 1'b1;
                abort_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // FSM and counter state; reset drops access and clears the count at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= 1'b0;
            cur_src_q <= '0;
            cur_dst_q <= '0;
            rem_q     <= '0;
            data_q    <= '0;
            abort_q   <= 1'b0;
            fill_q    <= 1'b0;
            intr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cur_src_q <= cur_src_d;
            cur_dst_q <= cur_dst_d;
            rem_q     <= rem_d;
            data_q    <= data_d;
            abort_q   <= abort_d;
            fill_q    <= fill_d;
            intr_q    <= intr_d;
        end
    end

    assign dma_m.access  = acc_q;
    assign dma_m.wr_en   = acc_q && (state_q == WRITE);
    assign dma_m.addr    = !acc_q ? '0 : ((state_q == WRITE) ? cur_dst_q : cur_src_q);
    assign dma_m.wdata   = (acc_q && (state_q == WRITE)) ? data_q : '0;
    assign dma_m.bytesel = 2'b11;
    assign intr          = intr_q;

endmodule
